// File: rtl/vga_scan_timing_if.sv
// -----------------------------------------------------------------------------
// vga_scan_timing_if
// Pixel-path bundle between the scan timing generator and its neighbours.
//   master : timing generator (drives scan coordinates, sync and colour pins,
//            consumes the composited colour coming back from the sprite mux)
//   slave  : sprite/background mux plus VGA connector side
// Signals:
//   DrawX, DrawY   10-bit scan coordinates
//   blank          1 = (DrawX, DrawY) is visible, undelayed
//   frame_start    one-cycle pulse at (0,0)
//   red/green/blue_in   4-bit composited colour, PIX_LAT cycles behind DrawX/Y
//   hs, vs         active-low syncs aligned to the colour pins
//   red/green/blue_out  registered VGA colour pins
//   test_mode      colour-bar select (only with VGA_TEST_PATTERN_EN defined)
// -----------------------------------------------------------------------------
interface vga_scan_timing_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       frame_start;
  logic [3:0] red_in;
  logic [3:0] green_in;
  logic [3:0] blue_in;
  logic       hs;
  logic       vs;
  logic [3:0] red_out;
  logic [3:0] green_out;
  logic [3:0] blue_out;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode;

  modport master (
    output DrawX, DrawY, blank, frame_start, hs, vs, red_out, green_out, blue_out,
    input  red_in, green_in, blue_in, test_mode
  );
  modport slave (
    input  DrawX, DrawY, blank, frame_start, hs, vs, red_out, green_out, blue_out,
    output red_in, green_in, blue_in, test_mode
  );
`else
  modport master (
    output DrawX, DrawY, blank, frame_start, hs, vs, red_out, green_out, blue_out,
    input  red_in, green_in, blue_in
  );
  modport slave (
    input  DrawX, DrawY, blank, frame_start, hs, vs, red_out, green_out, blue_out,
    output red_in, green_in, blue_in
  );
`endif
endinterface

// File: rtl/vga_scan_timing.sv
// -----------------------------------------------------------------------------
// vga_scan_timing
// Raster scan timing for 640x480@60. Produces DrawX/DrawY/blank/frame_start for
// the sprite renderers, takes their registered colour back PIX_LAT cycles later
// and drives hs/vs/colour pins with everything re-aligned (PIX_LAT+1 cycles
// from a counter value to its pins). Colour is forced black outside the
// visible area.
// Ports:
//   vga_clk  pixel clock, rising edge
//   reset    synchronous, active high
//   pix      vga_scan_timing_if.master (coordinates, syncs, colour in/out)
// Optional feature: define VGA_TEST_PATTERN_EN to add pix.test_mode, which
// replaces the colour inputs with 8 colour bars taken from DrawX[8:6].
// -----------------------------------------------------------------------------
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_LAT   = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_scan_timing_if.master pix
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_raw, hs_raw, vs_raw;

  // Alignment pipes: tap[0] is the undelayed term, tap[PIX_LAT] lines up with
  // the colour arriving on red_in/green_in/blue_in.
  logic [PIX_LAT:1] hs_pipe_q, vs_pipe_q, bl_pipe_q;
  logic [PIX_LAT:0] hs_tap, vs_tap, bl_tap;

  logic        hs_q, vs_q;
  logic [11:0] rgb_q, rgb_d;

  // Counters: vc only moves on the hc wrap cycle.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_MAX) begin
      hc_d = '0;
      vc_d = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
    end
  end

  assign blank_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_raw    = !((hc_q >= HS_LO) && (hc_q < HS_HI));
  assign vs_raw    = !((vc_q >= VS_LO) && (vc_q < VS_HI));

  assign hs_tap = {hs_pipe_q, hs_raw};
  assign vs_tap = {vs_pipe_q, vs_raw};
  assign bl_tap = {bl_pipe_q, blank_raw};

`ifdef VGA_TEST_PATTERN_EN
  // Bar index and mode travel with the pixel so test_mode can flip mid-frame.
  logic [PIX_LAT:1][2:0] bar_pipe_q;
  logic [PIX_LAT:0][2:0] bar_tap;
  logic [PIX_LAT:1]      tm_pipe_q;
  logic [PIX_LAT:0]      tm_tap;

  assign bar_tap = {bar_pipe_q, hc_q[8:6]};
  assign tm_tap  = {tm_pipe_q, pix.test_mode};

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      bar_pipe_q <= '0;
      tm_pipe_q  <= '0;
    end else begin
      bar_pipe_q <= bar_tap[PIX_LAT-1:0];
      tm_pipe_q  <= tm_tap[PIX_LAT-1:0];
    end
  end
`endif

  always_comb begin
    rgb_d = '0;
    if (bl_tap[PIX_LAT]) begin
      rgb_d = {pix.red_in, pix.green_in, pix.blue_in};
`ifdef VGA_TEST_PATTERN_EN
      if (tm_tap[PIX_LAT])
        rgb_d = {{4{bar_tap[PIX_LAT][0]}}, {4{bar_tap[PIX_LAT][1]}},
                 {4{bar_tap[PIX_LAT][2]}}};
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q      <= '0;
      vc_q      <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      bl_pipe_q <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hs_pipe_q <= hs_tap[PIX_LAT-1:0];
      vs_pipe_q <= vs_tap[PIX_LAT-1:0];
      bl_pipe_q <= bl_tap[PIX_LAT-1:0];
      hs_q      <= hs_tap[PIX_LAT];
      vs_q      <= vs_tap[PIX_LAT];
      rgb_q     <= rgb_d;
    end
  end

  assign pix.DrawX       = hc_q;
  assign pix.DrawY       = vc_q;
  assign pix.blank       = blank_raw;
  assign pix.frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
  assign pix.hs          = hs_q;
  assign pix.vs          = vs_q;
  assign pix.red_out     = rgb_q[11:8];
  assign pix.green_out   = rgb_q[7:4];
  assign pix.blue_out    = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_timing.sv
module tb_vga_scan_timing;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  vga_scan_timing_if if1 ();
  vga_scan_timing_if if3 ();
  vga_scan_timing_if ifs ();

  // u1/u3: full 640x480 timing; us: shrunk geometry so whole frames fit.
  vga_scan_timing #(.PIX_LAT(1)) u1 (.vga_clk(vga_clk), .reset(reset), .pix(if1));
  vga_scan_timing #(.PIX_LAT(3)) u3 (.vga_clk(vga_clk), .reset(reset), .pix(if3));
  vga_scan_timing #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .PIX_LAT(2)) us (.vga_clk(vga_clk), .reset(reset), .pix(ifs));

  int checks = 0, errors = 0;
  int t = 0;          // cycles since the last reset edge (0 while in reset)
  int seg = 0;
  int mis1 = 0, mis3 = 0, miss = 0;
  int hs1_low = 0, vss_low = 0, run = 0, run_max = 0;
  int fs_last = -1, fs_period = 0;
  int snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: returns 1 when the observed pins disagree.
  function automatic bit differs(input int tt, input int lat,
      input int hv, input int hf, input int hsy, input int hb,
      input int vv, input int vf, input int vsy, input int vb, input bit tm_inst,
      input logic [9:0] dx, input logic [9:0] dy, input logic bl, input logic fs,
      input logic hs, input logic vs, input logic [11:0] rgb);
    int ht, vt, p, ph, pv, bar;
    logic [9:0] edx, edy;
    logic ebl, efs, ehs, evs, vis, tm;
    logic [11:0] ergb;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    edx = 10'(tt % ht);
    edy = 10'((tt / ht) % vt);
    ebl = (int'(edx) < hv) && (int'(edy) < vv);
    efs = (edx == 0) && (edy == 0);
    p = tt - (lat + 1);
    ehs = 1'b1; evs = 1'b1; ergb = '0;
    if (p >= 0) begin
      ph  = p % ht;
      pv  = (p / ht) % vt;
      vis = (ph < hv) && (pv < vv);
      ehs = !((ph >= hv + hf) && (ph < hv + hf + hsy));
      evs = !((pv >= vv + vf) && (pv < vv + vf + vsy));
      tm  = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      tm = tm_inst && (seg == 0) && (p >= 700) && (p < 1590);
`endif
      bar = (ph >> 6) & 7;
      if (vis)
        ergb = tm ? {((bar & 1) != 0) ? 4'hF : 4'h0, ((bar & 2) != 0) ? 4'hF : 4'h0,
                     ((bar & 4) != 0) ? 4'hF : 4'h0}
                  : 12'hFA5;
    end
    return (dx !== edx) || (dy !== edy) || (bl !== ebl) || (fs !== efs) ||
           (hs !== ehs) || (vs !== evs) || (rgb !== ergb);
  endfunction

  task automatic tick();
    logic r;
    r = reset;
    @(posedge vga_clk);
    #1;
    if (r) begin
      t = 0; fs_last = -1; run = 0; run_max = 0;
    end else
      t = t + 1;
    mis1 += int'(differs(t, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, if1.DrawX, if1.DrawY,
                 if1.blank, if1.frame_start, if1.hs, if1.vs,
                 {if1.red_out, if1.green_out, if1.blue_out}));
    mis3 += int'(differs(t, 3, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, if3.DrawX, if3.DrawY,
                 if3.blank, if3.frame_start, if3.hs, if3.vs,
                 {if3.red_out, if3.green_out, if3.blue_out}));
    miss += int'(differs(t, 2, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, ifs.DrawX, ifs.DrawY,
                 ifs.blank, ifs.frame_start, ifs.hs, ifs.vs,
                 {ifs.red_out, ifs.green_out, ifs.blue_out}));
    if (!r) begin
      if (if1.hs === 1'b0) hs1_low++;
      if (ifs.vs === 1'b0) begin
        vss_low++; run++;
        if (run > run_max) run_max = run;
      end else run = 0;
      if (ifs.frame_start === 1'b1) begin
        if (fs_last >= 0) fs_period = t - fs_last;
        fs_last = t;
      end
    end
  endtask

  task automatic run_to(input int target);
    repeat (4000) begin
      if (t >= target) return;
      tick();
    end
    chk("run_to_bound", t, target);
  endtask

  initial begin
    if1.red_in = 4'hF; if1.green_in = 4'hA; if1.blue_in = 4'h5;
    if3.red_in = 4'hF; if3.green_in = 4'hA; if3.blue_in = 4'h5;
    ifs.red_in = 4'hF; ifs.green_in = 4'hA; ifs.blue_in = 4'h5;
`ifdef VGA_TEST_PATTERN_EN
    if1.test_mode = 1'b0; if3.test_mode = 1'b0; ifs.test_mode = 1'b0;
`endif
    // Reset held 5 cycles
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_drawx", if1.DrawX, 0);
    chk("rst_drawy", if1.DrawY, 0);
    chk("rst_fs", if1.frame_start, 1);
    chk("rst_blank", if1.blank, 1);
    chk("rst_hs", if1.hs, 1);
    chk("rst_vs", if1.vs, 1);
    chk("rst_rgb", {if1.red_out, if1.green_out, if1.blue_out}, 0);
    chk("rst_u3_rgb", {if3.red_out, if3.green_out, if3.blue_out}, 0);

    reset = 1'b0;
    tick();
    chk("rel_drawx", if1.DrawX, 1);
    chk("rel_drawy", if1.DrawY, 0);
    chk("rel_fs", if1.frame_start, 0);
    chk("rel_red", if1.red_out, 0);
    tick();
    chk("t2_red", if1.red_out, 4'hF);
    chk("t2_green", if1.green_out, 4'hA);
    chk("t2_u3_red", if3.red_out, 0);
    run_to(4);
    chk("t4_u3_red", if3.red_out, 4'hF);

    // Shrunk-geometry frames: period 120, vsync 2 lines of 15
    run_to(120);
    chk("s_fs1", ifs.frame_start, 1);
    chk("s_xy", {ifs.DrawX, ifs.DrawY}, 0);
    snap = vss_low;
    run_to(240);
    chk("s_fs2", ifs.frame_start, 1);
    chk("s_fs_period", fs_period, 120);
    chk("s_vs_low", vss_low - snap, 30);
    chk("s_vs_run", run_max, 30);

    // Visible-edge and hsync boundaries of line 0
    run_to(639);
    chk("blank_639", if1.blank, 1);
    run_to(640);
    chk("blank_640", if1.blank, 0);
    chk("red_640", if1.red_out, 4'hF);
    run_to(641);
    chk("red_641", if1.red_out, 4'hF);
    run_to(642);
    chk("red_642", if1.red_out, 0);
    run_to(643);
    chk("u3_red_643", if3.red_out, 4'hF);
    run_to(644);
    chk("u3_red_644", if3.red_out, 0);
    run_to(657);
    chk("hs_657", if1.hs, 1);
    run_to(658);
    chk("hs_658", if1.hs, 0);
    run_to(659);
    chk("u3_hs_659", if3.hs, 1);
    run_to(660);
    chk("u3_hs_660", if3.hs, 0);
`ifdef VGA_TEST_PATTERN_EN
    run_to(700);
    if1.test_mode = 1'b1;
`endif
    run_to(800);
    chk("l1_drawx", if1.DrawX, 0);
    chk("l1_drawy", if1.DrawY, 1);
    snap = hs1_low;
`ifdef VGA_TEST_PATTERN_EN
    run_to(812);
    chk("tp_bar0", {if1.red_out, if1.green_out, if1.blue_out}, 12'h000);
    run_to(866);
    chk("tp_bar1", {if1.red_out, if1.green_out, if1.blue_out}, 12'hF00);
    run_to(1252);
    chk("tp_bar7", {if1.red_out, if1.green_out, if1.blue_out}, 12'hFFF);
    run_to(1441);
    chk("tp_x639", {if1.red_out, if1.green_out, if1.blue_out}, 12'hF00);
    run_to(1442);
    chk("tp_blank", {if1.red_out, if1.green_out, if1.blue_out}, 12'h000);
    run_to(1590);
    if1.test_mode = 1'b0;
`endif
    run_to(1600);
    chk("l1_hs_low", hs1_low - snap, 96);
    chk("l2_drawy", if1.DrawY, 2);

    // Mid-frame reset (us is inside its vsync lines here)
    run_to(1900);
    chk("pre_drawx", if1.DrawX, 300);
    chk("pre_s_vs", ifs.vs, 0);
    reset = 1'b1;
    seg = 1;
    tick();
    chk("mid_xy", {if1.DrawX, if1.DrawY}, 0);
    chk("mid_hsvs", {if1.hs, if1.vs}, 2'b11);
    chk("mid_rgb", {if1.red_out, if1.green_out, if1.blue_out}, 0);
    chk("mid_s_xy", {ifs.DrawX, ifs.DrawY}, 0);
    chk("mid_s_hsvs", {ifs.hs, ifs.vs}, 2'b11);
    tick();
    chk("mid_fs", if1.frame_start, 1);
    chk("mid_blank", if1.blank, 1);
    chk("mid_rgb2", {if1.red_out, if1.green_out, if1.blue_out}, 0);
    reset = 1'b0;
    tick();
    chk("rel2_drawx", if1.DrawX, 1);
    run_to(120);
    chk("r_s_fs1", ifs.frame_start, 1);
    snap = vss_low;
    run_to(240);
    chk("r_s_fs_period", fs_period, 120);
    chk("r_s_vs_low", vss_low - snap, 30);
    chk("r_s_vs_run", run_max, 30);

    chk("model_u1", mis1, 0);
    chk("model_u3", mis3, 0);
    chk("model_us", miss, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
